aes_host_io: RTL and testbench

Host-side word interface for the AES-128 encryption core: the other end of the core's start/result register interface. It collects a 128-bit key and a 128-bit plaintext block as 32-bit writes and fires a one-cycle start strobe into the core's register stage. It then waits for the core's unmask/result strobe, captures the 128-bit result and streams it back to the host as four 32-bit words over a valid/ready handshake. It also supervises core latency with a timeout and forwards key-destruction requests.

---
 rtl/aes_host_io_if.sv | 24 ++
 rtl/aes_host_io.sv | 165 ++++++++++++++++
 tb/tb_aes_host_io.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_host_io_if.sv
// rtl/aes_host_io_if.sv - host-side word write / result read bundle for aes_host_io
interface aes_host_io_if;
    logic        wr_en_i;
    logic [2:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        go_i;
    logic        destroy_i;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [31:0] rd_data_o;
    logic        rd_last_o;
    logic        busy_o;
    logic [1:0]  err_o;

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, go_i, destroy_i, rd_ready_i,
        output rd_valid_o, rd_data_o, rd_last_o, busy_o, err_o
    );

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, go_i, destroy_i, rd_ready_i,
        input  rd_valid_o, rd_data_o, rd_last_o, busy_o, err_o
    );
endinterface

// File: rtl/aes_host_io.sv
// rtl/aes_host_io.sv - loads key/plaintext words, starts the AES core, supervises latency, drains the result
module aes_host_io #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                srst_ni,
    aes_host_io_if.slave        host,
    output logic                start_o,
    output logic [127:0]        key_o,
    output logic [127:0]        state_o,
    output logic                key_destruct_o,
    input  logic                core_done_i,
    input  logic [127:0]        result_i
);

    // Timeout fires in the RUN cycle whose increment would reach TIMEOUT_CYCLES-1.
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] data_q, data_d;
    logic [127:0] result_q, result_d;
    logic [3:0]   kf_q, kf_d;
    logic [3:0]   df_q, df_d;
    logic [9:0]   cnt_q, cnt_d;
    logic [1:0]   widx_q, widx_d;
    logic [1:0]   err_q, err_d;
    logic         kd_q, kd_d;

    logic [6:0]   wr_lsb;
    logic [6:0]   rd_lsb;

    // Word 0 of each 128-bit register sits in the top bits.
    assign wr_lsb = {~host.wr_addr_i[1:0], 5'd0};
    assign rd_lsb = {~widx_q, 5'd0};

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            kf_q     <= '0;
            df_q     <= '0;
            cnt_q    <= '0;
            widx_q   <= '0;
            err_q    <= '0;
            kd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            data_q   <= data_d;
            result_q <= result_d;
            kf_q     <= kf_d;
            df_q     <= df_d;
            cnt_q    <= cnt_d;
            widx_q   <= widx_d;
            err_q    <= err_d;
            kd_q     <= kd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        data_d   = data_q;
        result_d = result_q;
        kf_d     = kf_q;
        df_d     = df_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        err_d    = err_q;
        kd_d     = 1'b0;

        if (host.destroy_i) begin
            key_d    = '0;
            data_d   = '0;
            result_d = '0;
            kf_d     = '0;
            df_d     = '0;
            cnt_d    = '0;
            widx_d   = '0;
            kd_d     = 1'b1;
            state_d  = ST_IDLE;
        end else begin
            if ((state_q != ST_IDLE) && (host.wr_en_i || host.go_i)) begin
                err_d[0] = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (host.wr_en_i) begin
                        if (host.wr_addr_i[2]) begin
                            data_d[wr_lsb +: 32]    = host.wr_data_i;
                            df_d[host.wr_addr_i[1:0]] = 1'b1;
                        end else begin
                            key_d[wr_lsb +: 32]     = host.wr_data_i;
                            kf_d[host.wr_addr_i[1:0]] = 1'b1;
                        end
                    end
                    // Flag check deliberately uses the pre-write flags.
                    if (host.go_i) begin
                        if ((&kf_q) && (&df_q)) begin
                            err_d   = '0;
                            state_d = ST_START;
                        end else begin
                            err_d[0] = 1'b1;
                        end
                    end
                end

                ST_START: begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end

                ST_RUN: begin
                    if (core_done_i) begin
                        result_d = result_i;
                        widx_d   = '0;
                        state_d  = ST_DRAIN;
                    end else if (cnt_q == CNT_LAST) begin
                        err_d[1] = 1'b1;
                        kd_d     = 1'b1;
                        kf_d     = '0;
                        df_d     = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end

                ST_DRAIN: begin
                    if (host.rd_ready_i) begin
                        widx_d = widx_q + 2'd1;
                        if (widx_q == 2'd3) begin
                            df_d    = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign start_o         = (state_q == ST_START);
    assign key_o           = key_q;
    assign state_o         = data_q;
    assign key_destruct_o  = kd_q;
    assign host.rd_valid_o = (state_q == ST_DRAIN);
    assign host.rd_data_o  = result_q[rd_lsb +: 32];
    assign host.rd_last_o  = (state_q == ST_DRAIN) && (widx_q == 2'd3);
    assign host.busy_o     = (state_q != ST_IDLE);
    assign host.err_o      = err_q;

endmodule

// File: tb/tb_aes_host_io.sv
// tb/tb_aes_host_io.sv - directed bench for aes_host_io (default timeout unit plus an 8-cycle timeout unit)
module tb_aes_host_io;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst_n;

    aes_host_io_if h1 ();
    aes_host_io_if h2 ();

    logic         start1, kd1, done1;
    logic [127:0] key1, st1, res1;
    logic         start2, kd2, done2;
    logic [127:0] key2, st2, res2;

    aes_host_io #(.TIMEOUT_CYCLES(64)) dut (
        .clk_i          (clk),
        .srst_ni        (srst_n),
        .host           (h1),
        .start_o        (start1),
        .key_o          (key1),
        .state_o        (st1),
        .key_destruct_o (kd1),
        .core_done_i    (done1),
        .result_i       (res1)
    );

    aes_host_io #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk_i          (clk),
        .srst_ni        (srst_n),
        .host           (h2),
        .start_o        (start2),
        .key_o          (key2),
        .state_o        (st2),
        .key_destruct_o (kd2),
        .core_done_i    (done2),
        .result_i       (res2)
    );

    int total = 0;
    int bad   = 0;

    logic [127:0] key_v, pt_v, ct_v, pt2_v, r2_v;
    logic         rdy_tab [8];
    int           idx_tab [8];
    int           nstart;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [127:0] v, input int i);
        return v[(3 - i) * 32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input logic [2:0] a, input logic [31:0] d);
        h1.wr_en_i = 1'b1; h1.wr_addr_i = a; h1.wr_data_i = d;
        tick();
        h1.wr_en_i = 1'b0;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [31:0] d);
        h2.wr_en_i = 1'b1; h2.wr_addr_i = a; h2.wr_data_i = d;
        tick();
        h2.wr_en_i = 1'b0;
    endtask

    initial begin
        key_v = 128'h000102030405060708090a0b0c0d0e0f;
        pt_v  = 128'h00112233445566778899aabbccddeeff;
        ct_v  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt2_v = 128'h11111111222222223333333344444444;
        r2_v  = 128'h0123456789abcdeffedcba9876543210;
        rdy_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        idx_tab = '{0, 0, 0, 1, 1, 2, 3, 3};

        srst_n = 1'b0;
        h1.wr_en_i = 0; h1.wr_addr_i = 0; h1.wr_data_i = 0; h1.go_i = 0; h1.destroy_i = 0; h1.rd_ready_i = 0;
        h2.wr_en_i = 0; h2.wr_addr_i = 0; h2.wr_data_i = 0; h2.go_i = 0; h2.destroy_i = 0; h2.rd_ready_i = 0;
        done1 = 0; res1 = '0; done2 = 0; res2 = '0;
        tick(); tick();

        chk("rst_start", start1, 1'b0);
        chk("rst_kd", kd1, 1'b0);
        chk("rst_busy", h1.busy_o, 1'b0);
        chk("rst_valid", h1.rd_valid_o, 1'b0);
        chk("rst_last", h1.rd_last_o, 1'b0);
        chk("rst_data", h1.rd_data_o, 32'h0);
        chk("rst_err", h1.err_o, 2'b00);
        chk("rst_key", key1, 128'h0);
        chk("rst_state", st1, 128'h0);
        srst_n = 1'b1;

        // missing data word 7
        for (int i = 0; i < 4; i++) wr1(3'(i), word(key_v, i));
        for (int i = 0; i < 3; i++) wr1(3'(4 + i), word(pt_v, i));
        h1.go_i = 1'b1; tick(); h1.go_i = 1'b0;
        chk("miss_err", h1.err_o, 2'b01);
        chk("miss_busy", h1.busy_o, 1'b0);
        chk("miss_start", start1, 1'b0);
        tick();
        chk("miss_start2", start1, 1'b0);
        chk("miss_busy2", h1.busy_o, 1'b0);

        // FIPS-197 C.1
        wr1(3'd7, word(pt_v, 3));
        h1.go_i = 1'b1; tick(); h1.go_i = 1'b0;
        chk("c1_start", start1, 1'b1);
        chk("c1_busy", h1.busy_o, 1'b1);
        chk("c1_err_clr", h1.err_o, 2'b00);
        chk("c1_key", key1, key_v);
        chk("c1_state", st1, pt_v);
        tick();
        chk("c1_start_off", start1, 1'b0);
        nstart = 0;
        repeat (9) begin
            tick();
            if (start1) nstart++;
        end
        chk("c1_start_once", nstart, 0);
        done1 = 1'b1; res1 = ct_v; tick(); done1 = 1'b0; res1 = '0;
        chk("c1_valid", h1.rd_valid_o, 1'b1);
        h1.rd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("c1_word", h1.rd_data_o, word(ct_v, i));
            chk("c1_last", h1.rd_last_o, (i == 3));
            tick();
        end
        h1.rd_ready_i = 1'b0;
        chk("c1_valid_end", h1.rd_valid_o, 1'b0);
        chk("c1_busy_end", h1.busy_o, 1'b0);

        // key reuse: data must be reloaded
        h1.go_i = 1'b1; tick(); h1.go_i = 1'b0;
        chk("reuse_nodata_err", h1.err_o, 2'b01);
        chk("reuse_nodata_start", start1, 1'b0);
        for (int i = 0; i < 4; i++) wr1(3'(4 + i), word(pt2_v, i));
        h1.go_i = 1'b1; tick(); h1.go_i = 1'b0;
        chk("reuse_start", start1, 1'b1);
        chk("reuse_err_clr", h1.err_o, 2'b00);
        tick();
        wr1(3'd2, 32'hdeadbeef);
        chk("busy_wr_err", h1.err_o, 2'b01);
        chk("busy_wr_key", key1, key_v);
        chk("busy_wr_busy", h1.busy_o, 1'b1);
        done1 = 1'b1; res1 = r2_v; tick(); done1 = 1'b0; res1 = '0;
        chk("reuse_valid", h1.rd_valid_o, 1'b1);
        chk("reuse_state", st1, pt2_v);

        // backpressure drain
        for (int s = 0; s < 8; s++) begin
            h1.rd_ready_i = rdy_tab[s];
            chk("bp_valid", h1.rd_valid_o, 1'b1);
            chk("bp_word", h1.rd_data_o, word(r2_v, idx_tab[s]));
            chk("bp_last", h1.rd_last_o, (idx_tab[s] == 3));
            tick();
        end
        h1.rd_ready_i = 1'b0;
        chk("bp_valid_end", h1.rd_valid_o, 1'b0);
        chk("bp_busy_end", h1.busy_o, 1'b0);

        // destroy mid-drain
        for (int i = 0; i < 4; i++) wr1(3'(4 + i), word(pt_v, i));
        h1.go_i = 1'b1; tick(); h1.go_i = 1'b0;
        chk("ds_start", start1, 1'b1);
        tick();
        done1 = 1'b1; res1 = ct_v; tick(); done1 = 1'b0; res1 = '0;
        h1.rd_ready_i = 1'b1; tick(); tick(); h1.rd_ready_i = 1'b0;
        chk("ds_word2", h1.rd_data_o, word(ct_v, 2));
        h1.destroy_i = 1'b1; tick(); h1.destroy_i = 1'b0;
        chk("ds_valid", h1.rd_valid_o, 1'b0);
        chk("ds_key", key1, 128'h0);
        chk("ds_state", st1, 128'h0);
        chk("ds_kd", kd1, 1'b1);
        chk("ds_busy", h1.busy_o, 1'b0);
        chk("ds_data", h1.rd_data_o, 32'h0);
        tick();
        chk("ds_kd_once", kd1, 1'b0);

        // timeout on the 8-cycle unit
        for (int i = 0; i < 4; i++) wr2(3'(i), word(key_v, i));
        for (int i = 0; i < 4; i++) wr2(3'(4 + i), word(pt_v, i));
        h2.go_i = 1'b1; tick(); h2.go_i = 1'b0;
        chk("to_start", start2, 1'b1);
        repeat (7) tick();
        chk("to_pre_err", h2.err_o, 2'b00);
        chk("to_pre_busy", h2.busy_o, 1'b1);
        chk("to_pre_kd", kd2, 1'b0);
        tick();
        chk("to_err", h2.err_o, 2'b10);
        chk("to_kd", kd2, 1'b1);
        chk("to_busy", h2.busy_o, 1'b0);
        tick();
        chk("to_kd_once", kd2, 1'b0);
        h2.go_i = 1'b1; tick(); h2.go_i = 1'b0;
        chk("to_go_rej_start", start2, 1'b0);
        chk("to_go_rej_err", h2.err_o, 2'b11);
        for (int i = 0; i < 4; i++) wr2(3'(4 + i), word(pt_v, i));
        h2.go_i = 1'b1; tick(); h2.go_i = 1'b0;
        chk("to_data_only_rej", start2, 1'b0);
        for (int i = 0; i < 4; i++) wr2(3'(i), word(key_v, i));
        h2.go_i = 1'b1; tick(); h2.go_i = 1'b0;
        chk("to_reload_start", start2, 1'b1);
        chk("to_reload_err", h2.err_o, 2'b00);

        // reset mid-run is silent
        tick();
        srst_n = 1'b0; tick(); srst_n = 1'b1;
        chk("rr_kd", kd2, 1'b0);
        chk("rr_err", h2.err_o, 2'b00);
        chk("rr_busy", h2.busy_o, 1'b0);
        chk("rr_key", key2, 128'h0);
        tick();
        chk("rr_kd2", kd2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
